// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory bus arbiter.
// ROUND_ROBIN_EN (optional) switches the winner select from fixed priority to alternating.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;

    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_TIMEOUT_CYC = 255;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between fetch and data ports. Fixed priority (dm over if) by default;
// with ROUND_ROBIN_EN a last_grant register makes simultaneous requests alternate.
module mem_arb_pick
    import mem_arb_pkg::*;
(
`ifdef ROUND_ROBIN_EN
    input  logic clk,
    input  logic reset,
    input  logic accept_i,
`endif
    input  logic if_valid_i,
    input  logic dm_valid_i,
    output logic any_o,
    output logic grant_o
);

    assign any_o = if_valid_i | dm_valid_i;

`ifdef ROUND_ROBIN_EN
    logic last_grant_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= PORT_IF;
        end else if (accept_i) begin
            last_grant_q <= grant_o;
        end
    end

    always_comb begin
        grant_o = PORT_IF;
        if (if_valid_i && dm_valid_i) begin
            grant_o = ~last_grant_q;
        end else if (dm_valid_i) begin
            grant_o = PORT_DM;
        end
    end
`else
    assign grant_o = dm_valid_i ? PORT_DM : PORT_IF;
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-outstanding A/D bus arbiter for fetch (port 0) and data (port 1) with response timeout.
// Build option ROUND_ROBIN_EN: alternate grants on simultaneous requests.
//   state | meaning
//   IDLE  | waiting for a request; accepts and latches the winner
//   ADDR  | a_valid held with latched request until a_ready
//   RESP  | d_ready high, waiting for d_valid or the timeout
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rsp_valid,
    input  logic              dm_req_valid,
    output logic              dm_req_ready,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic              dm_we,
    output logic              dm_rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              a_valid,
    input  logic              a_ready,
    output logic [ADDR_W-1:0] a_addr,
    output logic [DATA_W-1:0] a_wdata,
    output logic              a_we,
    input  logic              d_valid,
    output logic              d_ready,
    input  logic [DATA_W-1:0] d_data,
    output logic              busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    arb_state_e        state_q, state_d;
    logic              grant_q, grant_d;
    logic [ADDR_W-1:0] a_addr_q, a_addr_d;
    logic [DATA_W-1:0] a_wdata_q, a_wdata_d;
    logic              a_we_q, a_we_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              if_rsp_q, if_rsp_d;
    logic              dm_rsp_q, dm_rsp_d;

    logic pick_any;
    logic pick_grant;
    logic accept;

    mem_arb_pick u_pick (
`ifdef ROUND_ROBIN_EN
        .clk        (clk),
        .reset      (reset),
        .accept_i   (accept),
`endif
        .if_valid_i (if_req_valid),
        .dm_valid_i (dm_req_valid),
        .any_o      (pick_any),
        .grant_o    (pick_grant)
    );

    // Gating with reset keeps both ready outputs low while reset is held.
    assign accept       = (state_q == IDLE) && pick_any && !reset;
    assign if_req_ready = accept && (pick_grant == PORT_IF);
    assign dm_req_ready = accept && (pick_grant == PORT_DM);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        a_addr_d   = a_addr_q;
        a_wdata_d  = a_wdata_q;
        a_we_d     = a_we_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        if_rsp_d   = 1'b0;
        dm_rsp_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    grant_d = pick_grant;
                    if (pick_grant == PORT_DM) begin
                        a_addr_d  = dm_addr;
                        a_wdata_d = dm_wdata;
                        a_we_d    = dm_we;
                    end else begin
                        a_addr_d  = if_addr;
                        a_wdata_d = '0;
                        a_we_d    = 1'b0;
                    end
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (a_ready) begin
                    cnt_d   = '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                // A response arriving on the timeout cycle still counts as good data.
                if (d_valid) begin
                    rsp_data_d = d_data;
                    rsp_err_d  = 1'b0;
                    if_rsp_d   = (grant_q == PORT_IF);
                    dm_rsp_d   = (grant_q == PORT_DM);
                    state_d    = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    if_rsp_d   = (grant_q == PORT_IF);
                    dm_rsp_d   = (grant_q == PORT_DM);
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= PORT_IF;
            a_addr_q   <= '0;
            a_wdata_q  <= '0;
            a_we_q     <= 1'b0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            if_rsp_q   <= 1'b0;
            dm_rsp_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            a_addr_q   <= a_addr_d;
            a_wdata_q  <= a_wdata_d;
            a_we_q     <= a_we_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            if_rsp_q   <= if_rsp_d;
            dm_rsp_q   <= dm_rsp_d;
        end
    end

    assign a_valid      = (state_q == ADDR);
    assign a_addr       = a_addr_q;
    assign a_wdata      = a_wdata_q;
    assign a_we         = a_we_q;
    assign d_ready      = (state_q != ADDR);
    assign busy         = (state_q != IDLE);
    assign rsp_data     = rsp_data_q;
    assign rsp_err      = rsp_err_q;
    assign if_rsp_valid = if_rsp_q;
    assign dm_rsp_valid = dm_rsp_q;

endmodule
